// File: rtl/capture_pkg.sv
// capture_sequencer shared types.
// State encoding and the sample acceptance window test.
package capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4,
    S_HOLDOFF = 3'd5
  } cap_state_t;

  localparam int WIN_W = 32;

  // lo inclusive, hi exclusive, unsigned
  function automatic logic in_window(
    input logic [WIN_W-1:0] sample,
    input logic [WIN_W-1:0] lo,
    input logic [WIN_W-1:0] hi
  );
    return (sample >= lo) && (sample < hi);
  endfunction

endpackage

// File: rtl/capture_if.sv
// Sample/readout bundle between the ADC driver,
// the SPI readout path and capture_sequencer.
interface capture_if #(
  parameter int DATA_W = 16
) ();

  logic              arm;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              rd_req;
  logic              frame_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              overrun;
  logic [2:0]        state_o;

  modport master (
    output arm,
    output sample_in,
    output sample_valid,
    output rd_req,
    input  frame_ready,
    input  rd_data,
    input  rd_valid,
    input  overrun,
    input  state_o
  );

  modport slave (
    input  arm,
    input  sample_in,
    input  sample_valid,
    input  rd_req,
    output frame_ready,
    output rd_data,
    output rd_valid,
    output overrun,
    output state_o
  );

endinterface

// File: rtl/capture_ram.sv
// Capture ring storage: one write port,
// one registered read port (1-cycle latency).
module capture_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_sequencer.sv
// Pulse capture: pre-trigger ring history, run-length
// trigger, post window, then frozen word-by-word readout.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int                DATA_W             = 16,
  parameter int                ADDR_W             = 10,
  parameter int                PRE_SAMPLES        = 500,
  parameter int                POST_SAMPLES       = 500,
  parameter logic [DATA_W-1:0] VALID_VOLTAGE      = DATA_W'(32),
  parameter logic [DATA_W-1:0] NEG_LIMIT          = DATA_W'(16'hF800),
  parameter int                VALID_COUNT_NEEDED = 20,
  parameter int                HOLDOFF_CYCLES     = 1000
) (
  input logic       clk,
  input logic       rst,
  capture_if.slave  bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int RUN_W = $clog2(VALID_COUNT_NEEDED + 1);
  localparam int HLD_W = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [CNT_W-1:0] PRE_LAST =
    CNT_W'(PRE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] POST_LAST =
    CNT_W'(POST_SAMPLES - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST =
    CNT_W'(PRE_SAMPLES + POST_SAMPLES - 1);
  localparam logic [RUN_W-1:0] RUN_MAX =
    RUN_W'(VALID_COUNT_NEEDED);
  localparam logic [HLD_W-1:0] HLD_LAST =
    HLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PRE_OFF =
    ADDR_W'(PRE_SAMPLES - 1);

  if (PRE_SAMPLES < 1 || POST_SAMPLES < 1 ||
      VALID_COUNT_NEEDED < 1 || HOLDOFF_CYCLES < 1 ||
      PRE_SAMPLES + POST_SAMPLES > (1 << ADDR_W))
  begin : g_cfg_err
    $error("capture_sequencer: invalid frame configuration");
  end

  cap_state_t        state;
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] trig_addr;
  logic [CNT_W-1:0]  fill_cnt;
  logic [CNT_W-1:0]  post_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [HLD_W-1:0]  hold_cnt;
  logic              frame_ready;
  logic              rd_valid;
  logic              overrun;

  logic              valid_smp;
  logic              run_sat;
  logic [RUN_W-1:0]  run_next;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    valid_smp = in_window(WIN_W'(bus.sample_in),
                          WIN_W'(VALID_VOLTAGE),
                          WIN_W'(NEG_LIMIT));
    run_sat   = (run_cnt == RUN_MAX);
    run_next  = '0;
    unique case (1'b1)
      !valid_smp:            run_next = '0;
      valid_smp && run_sat:  run_next = RUN_MAX;
      valid_smp && !run_sat: run_next = run_cnt + 1'b1;
    endcase
  end

  assign we = bus.sample_valid && bus.arm &&
              (state == S_FILL || state == S_ARMED ||
               state == S_POST);
  assign re = bus.rd_req && bus.arm && (state == S_READOUT);

  // frame begins PRE_SAMPLES-1 words before the trigger
  assign start_addr = trig_addr - PRE_OFF;
  assign raddr      = start_addr + rd_cnt[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wp          <= '0;
      trig_addr   <= '0;
      fill_cnt    <= '0;
      post_cnt    <= '0;
      rd_cnt      <= '0;
      run_cnt     <= '0;
      hold_cnt    <= '0;
      frame_ready <= 1'b0;
      rd_valid    <= 1'b0;
      overrun     <= 1'b0;
    end else if (!bus.arm) begin
      state       <= S_IDLE;
      wp          <= '0;
      trig_addr   <= '0;
      fill_cnt    <= '0;
      post_cnt    <= '0;
      rd_cnt      <= '0;
      run_cnt     <= '0;
      hold_cnt    <= '0;
      frame_ready <= 1'b0;
      rd_valid    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          state    <= S_FILL;
          fill_cnt <= '0;
          run_cnt  <= '0;
        end
        S_FILL: if (bus.sample_valid) begin
          wp       <= wp + 1'b1;
          run_cnt  <= run_next;
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == PRE_LAST) state <= S_ARMED;
        end
        S_ARMED: if (bus.sample_valid) begin
          wp      <= wp + 1'b1;
          run_cnt <= run_next;
          if (run_next == RUN_MAX) begin
            trig_addr <= wp;
            post_cnt  <= '0;
            state     <= S_POST;
          end
        end
        S_POST: if (bus.sample_valid) begin
          wp       <= wp + 1'b1;
          post_cnt <= post_cnt + 1'b1;
          if (post_cnt == POST_LAST) begin
            state       <= S_READOUT;
            frame_ready <= 1'b1;
            rd_cnt      <= '0;
          end
        end
        S_READOUT: begin
          if (bus.sample_valid) overrun <= 1'b1;
          rd_valid <= bus.rd_req;
          if (bus.rd_req) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == FRAME_LAST) begin
              state       <= S_HOLDOFF;
              frame_ready <= 1'b0;
              hold_cnt    <= '0;
            end
          end
        end
        S_HOLDOFF: begin
          if (bus.sample_valid) overrun <= 1'b1;
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HLD_LAST) begin
            state    <= S_FILL;
            fill_cnt <= '0;
            run_cnt  <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wp),
    .wdata (bus.sample_in),
    .re    (re),
    .raddr (raddr),
    .rdata (rd_data)
  );

  assign bus.frame_ready = frame_ready;
  assign bus.rd_data     = rd_data;
  assign bus.rd_valid    = rd_valid;
  assign bus.overrun     = overrun;
  assign bus.state_o     = state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer with
// ADDR_W=5, PRE=8, POST=8, run=3, holdoff=4.
module tb_capture_sequencer;
  import capture_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  capture_if #(.DATA_W(16)) bus ();

  capture_sequencer #(
    .DATA_W             (16),
    .ADDR_W             (5),
    .PRE_SAMPLES        (8),
    .POST_SAMPLES       (8),
    .VALID_VOLTAGE      (16'd32),
    .NEG_LIMIT          (16'hF800),
    .VALID_COUNT_NEEDED (3),
    .HOLDOFF_CYCLES     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] sb [$];
  logic [15:0] exp_frame [16];
  logic [15:0] mon_exp;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  name, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst && bus.rd_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_valid", 32'(bus.rd_valid), 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    bus.sample_in    = v;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic send_n(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) send(base + 16'(i));
  endtask

  task automatic chk_state(input string name, input cap_state_t st);
    check(name, 32'(bus.state_o), 32'(st));
  endtask

  task automatic read_frame(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.rd_req = 1'b1;
      sb.push_back(exp_frame[i]);
      tick();
      if (i == 14)
        check({tag, "_rdy_before_last"}, 32'(bus.frame_ready), 32'd1);
    end
    bus.rd_req = 1'b0;
    check({tag, "_rdy_fall"}, 32'(bus.frame_ready), 32'd0);
    check({tag, "_last_valid"}, 32'(bus.rd_valid), 32'd1);
    chk_state({tag, "_holdoff"}, S_HOLDOFF);
  endtask

  task automatic holdoff_chk(input string tag);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state({tag, "_hold"}, S_HOLDOFF);
    end
    tick();
    chk_state({tag, "_refill"}, S_FILL);
  endtask

  initial begin
    bus.arm          = 1'b0;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.rd_req       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_state("rst_state", S_IDLE);
    check("rst_frame_ready", 32'(bus.frame_ready), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b1;
    tick();
    chk_state("idle_unarmed", S_IDLE);

    // ramp, trigger on 102
    bus.arm = 1'b1;
    tick();
    chk_state("s1_fill", S_FILL);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("s1_rdreq_ignored", 32'(bus.rd_valid), 32'd0);
    send_n(16'd0, 7);
    chk_state("s1_fill7", S_FILL);
    send(16'd7);
    chk_state("s1_armed", S_ARMED);
    send(16'd8);
    send(16'd9);
    send(16'd100);
    send(16'd101);
    chk_state("s1_run2", S_ARMED);
    send(16'd102);
    chk_state("s1_trig", S_POST);
    send_n(16'd103, 7);
    chk_state("s1_post7", S_POST);
    check("s1_rdy_low", 32'(bus.frame_ready), 32'd0);
    send(16'd110);
    chk_state("s1_readout", S_READOUT);
    check("s1_rdy_rise", 32'(bus.frame_ready), 32'd1);
    exp_frame = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd9,
                  16'd100, 16'd101, 16'd102, 16'd103,
                  16'd104, 16'd105, 16'd106, 16'd107,
                  16'd108, 16'd109, 16'd110};
    read_frame("s1");
    holdoff_chk("s1");

    // broken run, frame wraps past 31
    send_n(16'd16, 8);
    chk_state("s2_armed", S_ARMED);
    send(16'd40);
    send(16'd41);
    send(16'hF900);
    chk_state("s2_broken", S_ARMED);
    send(16'd42);
    send(16'd43);
    chk_state("s2_run2", S_ARMED);
    send(16'd44);
    chk_state("s2_trig", S_POST);
    send_n(16'd45, 8);
    chk_state("s2_readout", S_READOUT);
    exp_frame = '{16'd22, 16'd23, 16'd40, 16'd41, 16'hF900,
                  16'd42, 16'd43, 16'd44, 16'd45, 16'd46,
                  16'd47, 16'd48, 16'd49, 16'd50, 16'd51,
                  16'd52};
    read_frame("s2");
    holdoff_chk("s2");

    // run completed during FILL
    send_n(16'd1, 5);
    send_n(16'd60, 3);
    chk_state("s3_armed", S_ARMED);
    send(16'd63);
    chk_state("s3_trig", S_POST);
    send_n(16'd64, 8);
    exp_frame = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd60,
                  16'd61, 16'd62, 16'd63, 16'd64, 16'd65,
                  16'd66, 16'd67, 16'd68, 16'd69, 16'd70,
                  16'd71};
    read_frame("s3");
    holdoff_chk("s3");
    bus.arm = 1'b0;
    tick();
    chk_state("s3_idle", S_IDLE);

    // 40 pre-trigger samples, overrun in READOUT
    bus.arm = 1'b1;
    tick();
    chk_state("s4_fill", S_FILL);
    send_n(16'hF800, 40);
    chk_state("s4_armed", S_ARMED);
    send_n(16'd300, 2);
    send(16'd302);
    chk_state("s4_trig", S_POST);
    send_n(16'd303, 8);
    chk_state("s4_readout", S_READOUT);
    check("s4_ovr_clear", 32'(bus.overrun), 32'd0);
    send(16'h1234);
    check("s4_ovr_set", 32'(bus.overrun), 32'd1);
    chk_state("s4_still_readout", S_READOUT);
    exp_frame = '{16'hF823, 16'hF824, 16'hF825, 16'hF826,
                  16'hF827, 16'd300, 16'd301, 16'd302,
                  16'd303, 16'd304, 16'd305, 16'd306,
                  16'd307, 16'd308, 16'd309, 16'd310};
    read_frame("s4");
    holdoff_chk("s4");
    check("s4_ovr_sticky", 32'(bus.overrun), 32'd1);
    bus.arm = 1'b0;
    tick();
    check("s4_ovr_idle", 32'(bus.overrun), 32'd0);
    chk_state("s4_idle", S_IDLE);

    // arm dropped mid-POST, then re-arm
    bus.arm = 1'b1;
    tick();
    send_n(16'd0, 8);
    chk_state("s6_armed", S_ARMED);
    send_n(16'd100, 3);
    chk_state("s6_trig", S_POST);
    send_n(16'd103, 3);
    bus.arm = 1'b0;
    tick();
    chk_state("s6_post_drop", S_IDLE);
    check("s6_post_drop_rdy", 32'(bus.frame_ready), 32'd0);
    bus.arm = 1'b1;
    tick();
    chk_state("s6_rearm", S_FILL);
    send_n(16'd50, 7);
    chk_state("s6_refill7", S_FILL);
    send(16'd57);
    chk_state("s6_rearmed", S_ARMED);
    send(16'd58);
    chk_state("s6_trig2", S_POST);
    send_n(16'd59, 8);
    chk_state("s6_readout", S_READOUT);
    check("s6_rdy", 32'(bus.frame_ready), 32'd1);

    // arm dropped mid-READOUT with a request pending
    for (int i = 0; i < 3; i++) begin
      bus.rd_req = 1'b1;
      sb.push_back(16'd51 + 16'(i));
      tick();
    end
    bus.arm = 1'b0;
    tick();
    chk_state("s6_rd_drop", S_IDLE);
    check("s6_rd_drop_rdy", 32'(bus.frame_ready), 32'd0);
    check("s6_rd_suppressed", 32'(bus.rd_valid), 32'd0);
    bus.rd_req = 1'b0;
    tick();
    check("s6_rd_quiet", 32'(bus.rd_valid), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Pulse-capture controller between the ADS8528 driver output (`data_out`/`data_valid`) and the SPI readout path. It keeps a circular pre-trigger history of samples and declares a pulse after a run of consecutive in-window samples. It then captures a fixed post-trigger window, freezes the buffer, and serves the frame word-by-word to the SPI side on request. It replaces the ad-hoc FILL/JUNK/DUMP sequencing with a single pointer-based ring buffer.

## Interface
- `DATA_W`, 16: sample width.
- `ADDR_W`, 10: ring depth is 2^ADDR_W. `PRE_SAMPLES + POST_SAMPLES <= 2^ADDR_W` is checked at elaboration.
- `PRE_SAMPLES`, 500: frame words up to and including the trigger sample; must be ≥1.
- `POST_SAMPLES`, 500: frame words after the trigger sample; must be ≥1.
- `VALID_VOLTAGE`, 16'd32: lower bound of the valid window, inclusive, unsigned compare.
- `NEG_LIMIT`, 16'hF800: upper bound of the valid window, exclusive, unsigned compare.
- `VALID_COUNT_NEEDED`, 20: consecutive valid samples that declare a pulse; must be ≥1.
- `HOLDOFF_CYCLES`, 1000: dead time in clocks after readout before re-filling; must be ≥1.
- `clk` in 1: system clock, the divided ADC clock.
- `rst` in 1: asynchronous, active-low reset.
- `arm` in 1: level enable; low forces IDLE.
- `sample_in` in DATA_W: sample from the driver.
- `sample_valid` in 1: one-cycle strobe qualifying `sample_in`.
- `rd_req` in 1: one-cycle request for the next frame word, synchronous to `clk`.
- `frame_ready` out 1: a frozen frame is available; mirrors SPI_RDY.
- `rd_data` out DATA_W: frame word.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `overrun` out 1: sticky; a sample arrived while the buffer was frozen or in holdoff. Cleared by entering IDLE.
- `state_o` out 3: current state encoding, for debug.

## Operation
- States: IDLE=0, FILL=1, ARMED=2, POST=3, READOUT=4, HOLDOFF=5.
- IDLE: no writes. Go to FILL when `arm`=1.
- `arm`=0 in any state: go to IDLE next cycle. This clears all counters and pointers, drops `frame_ready`, and discards any pending read.
- Write pointer `wp` (ADDR_W bits) wraps modulo 2^ADDR_W. In FILL, ARMED and POST, every `sample_valid` writes `sample_in` at `wp` and increments `wp`.
- Valid sample: `VALID_VOLTAGE <= sample_in < NEG_LIMIT`.
- Run counter:
  - A valid sample increments it, saturating at VALID_COUNT_NEEDED.
  - An invalid sample clears it to 0.
  - It updates in FILL and ARMED and is cleared on entry to FILL.
- FILL: count accepted samples. Go to ARMED on the cycle the PRE_SAMPLES-th sample is written.
- ARMED: a trigger occurs on an accepted sample whose updated run count reaches VALID_COUNT_NEEDED.
  - If the run already reached VALID_COUNT_NEEDED during FILL, the first valid sample in ARMED triggers.
  - On trigger, latch `trig_addr` = address of the trigger sample and go to POST.
- POST: write POST_SAMPLES further samples, then go to READOUT. The buffer is frozen.
- Frame start address: `trig_addr - (PRE_SAMPLES-1)`, modulo 2^ADDR_W.
- READOUT: `frame_ready`=1.
  - Each `rd_req` reads address start+`rd_cnt` and increments `rd_cnt`.
  - The request that accepts word PRE_SAMPLES+POST_SAMPLES-1 moves the state to HOLDOFF.
- HOLDOFF: count HOLDOFF_CYCLES clocks, then go to FILL. The fill count restarts from 0; old history is not reused.
- Frozen states (READOUT, HOLDOFF): `sample_valid` writes nothing and sets `overrun`.
- `rd_req` outside READOUT is ignored; `rd_valid` stays 0.

## Timing
- Reset values: `frame_ready`=0, `rd_valid`=0, `rd_data`=0, `overrun`=0, `state_o`=IDLE. All pointers and counters are 0.
- Sample write and counter updates happen at the posedge where `sample_valid`=1.
- State changes (FILL→ARMED, ARMED→POST, POST→READOUT) take effect the cycle after the qualifying sample.
- `frame_ready` rises the cycle after the last post sample is written.
- Read latency is 1: `rd_req` at cycle t gives `rd_data`/`rd_valid` at t+1. Back-to-back `rd_req` every cycle is supported.
- Last word: `frame_ready` falls at t+1, the same cycle the last `rd_valid` is high.
- HOLDOFF lasts exactly HOLDOFF_CYCLES cycles; FILL is entered on cycle HOLDOFF_CYCLES+1.
- `arm` falling while a read is pending: the pending `rd_valid` is suppressed.

## Structure
- Package `capture_pkg`: state enum `cap_state_t`, and function `in_window(sample, lo, hi)`.
- Sub-module `capture_ram`: simple dual-port RAM, 2^ADDR_W × DATA_W, one write port, registered read, 1-cycle latency. Inferred block RAM.
- `capture_sequencer` contains the FSM, pointers and counters only.

## Test plan
All scenarios use ADDR_W=5, PRE=8, POST=8, VALID_COUNT_NEEDED=3, HOLDOFF=4.
- Ramp samples 0,1,2…, all invalid (below 32), then samples 100,101,102 → trigger on 102. Reading 16 words returns the 5 samples before 100, then 100,101,102, then the next 8 samples. `frame_ready` falls with the 16th `rd_valid`.
- Two valid samples, one invalid (16'hF900), then three valid → trigger on the third sample of the second run only.
- Valid run of 3 completed inside FILL → trigger on the first valid sample after ARMED.
- Wrap case: 40 samples written before the trigger → frame addresses wrap past 31, and data order is preserved.
- `sample_valid` during READOUT → buffer contents unchanged and `overrun`=1. `overrun` stays 1 until `arm`=0.
- `arm` dropped mid-POST, and separately mid-READOUT → IDLE next cycle, `frame_ready`=0, no `rd_valid`. Re-arming re-fills 8 samples before any trigger.
